// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and IF/ID front end with branch redirect and stall hold
// Optional feature: PC_MISALIGN_TRAP_EN aligns redirect targets and pulses misalign.
module pc_fetch_unit #(
  parameter int               WIDTH    = 64,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] ifid_pc,
  output logic             ifid_valid,
  output logic             misalign
);

  typedef enum logic {BOOT, RUN} state_t;

  localparam logic [WIDTH-1:0] PC_STEP = {{(WIDTH-3){1'b0}}, 3'b100};

  state_t           state, state_next;
  logic [WIDTH-1:0] pc_next, ifid_pc_next, redirect_pc;
  logic             ifid_valid_next;

  assign pc_plus4 = pc + PC_STEP;

`ifdef PC_MISALIGN_TRAP_EN
  logic misalign_q, misalign_next;

  assign redirect_pc   = {br_target[WIDTH-1:2], 2'b00};
  assign misalign_next = br_taken && (br_target[1:0] != 2'b00);
  assign misalign      = misalign_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_next;
    end
  end
`else
  assign redirect_pc = br_target;
  assign misalign    = 1'b0;
`endif

  // Redirect beats stall; BOOT always advances so the first fetch enters IF/ID.
  always_comb begin
    state_next      = RUN;
    pc_next         = pc;
    ifid_pc_next    = ifid_pc;
    ifid_valid_next = ifid_valid;
    if (br_taken) begin
      pc_next         = redirect_pc;
      ifid_pc_next    = '0;
      ifid_valid_next = 1'b0;
    end else if (state == BOOT || !stall) begin
      pc_next         = pc_plus4;
      ifid_pc_next    = pc;
      ifid_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      ifid_pc    <= '0;
      ifid_valid <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      ifid_pc    <= ifid_pc_next;
      ifid_valid <= ifid_valid_next;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - randomized and directed checks of pc_fetch_unit against a reference model
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, br_taken;
  logic [63:0] br_target;
  logic [63:0] pc, pc_plus4, ifid_pc;
  logic        ifid_valid, misalign;

  int total = 0;
  int bad   = 0;

  logic [63:0] m_pc, m_ifid_pc;
  logic        m_valid, m_mis, m_boot;

  pc_fetch_unit #(.WIDTH(64), .RESET_PC(64'd0)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .ifid_pc    (ifid_pc),
    .ifid_valid (ifid_valid),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour applied once per rising edge from the current inputs.
  task automatic model_edge();
    if (reset) begin
      m_pc = 64'd0; m_ifid_pc = 64'd0; m_valid = 1'b0; m_mis = 1'b0; m_boot = 1'b1;
    end else begin
      m_mis = 1'b0;
      if (br_taken) begin
`ifdef PC_MISALIGN_TRAP_EN
        m_pc  = br_target & ~64'd3;
        m_mis = (br_target % 4) != 0;
`else
        m_pc  = br_target;
`endif
        m_ifid_pc = 64'd0;
        m_valid   = 1'b0;
      end else if (m_boot || !stall) begin
        m_ifid_pc = m_pc;
        m_valid   = 1'b1;
        m_pc      = m_pc + 64'd4;
      end
      m_boot = 1'b0;
    end
  endtask

  task automatic compare_model();
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 64'd4);
    check("ifid_pc", ifid_pc, m_ifid_pc);
    check("ifid_valid", 64'(ifid_valid), 64'(m_valid));
    check("misalign", 64'(misalign), 64'(m_mis));
  endtask

  task automatic step(input logic r, input logic s, input logic b, input logic [63:0] t);
    reset = r; stall = s; br_taken = b; br_target = t;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_model();
  endtask

  task automatic reach_0x40();
    step(1'b0, 1'b0, 1'b1, 64'h3C);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    check("at_0x40_pc", pc, 64'h40);
    check("at_0x40_valid", 64'(ifid_valid), 64'd1);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    m_pc = '0; m_ifid_pc = '0; m_valid = 1'b0; m_mis = 1'b0; m_boot = 1'b1;
    @(negedge clk);

    // 1: reset then sequential fetch
    step(1'b1, 1'b0, 1'b0, 64'h0);
    step(1'b1, 1'b0, 1'b0, 64'h0);
    check("reset_pc", pc, 64'h0);
    check("reset_valid", 64'(ifid_valid), 64'd0);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    check("boot_pc", pc, 64'h4);
    check("boot_ifid_pc", ifid_pc, 64'h0);
    check("boot_valid", 64'(ifid_valid), 64'd1);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    check("seq_pc_12", pc, 64'hC);
    check("seq_ifid_8", ifid_pc, 64'h8);

    // 2: stall holds everything
    reach_0x40();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 64'h0);
      check("stall_pc", pc, 64'h40);
      check("stall_ifid_pc", ifid_pc, 64'h3C);
      check("stall_valid", 64'(ifid_valid), 64'd1);
    end
    step(1'b0, 1'b0, 1'b0, 64'h0);
    check("stall_release_pc", pc, 64'h44);

    // 3: redirect with one bubble
    reach_0x40();
    step(1'b0, 1'b0, 1'b1, 64'h1000);
    check("redir_pc", pc, 64'h1000);
    check("redir_valid", 64'(ifid_valid), 64'd0);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    check("redir_ifid_pc", ifid_pc, 64'h1000);
    check("redir_ifid_valid", 64'(ifid_valid), 64'd1);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    check("redir_pc_1008", pc, 64'h1008);

    // 4: redirect wins over stall
    step(1'b0, 1'b1, 1'b1, 64'h200);
    check("br_over_stall_pc", pc, 64'h200);
    check("br_over_stall_valid", 64'(ifid_valid), 64'd0);

    // 5: wrap-around
    step(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_plus4", pc_plus4, 64'h0);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    check("wrap_pc", pc, 64'h0);
    check("wrap_ifid_pc", ifid_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // 6: misaligned redirect
    step(1'b0, 1'b0, 1'b1, 64'h103);
`ifdef PC_MISALIGN_TRAP_EN
    check("mis_pc", pc, 64'h100);
    check("mis_flag", 64'(misalign), 64'd1);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    check("mis_flag_clear", 64'(misalign), 64'd0);
    check("mis_pc_next", pc, 64'h104);
`else
    check("mis_pc", pc, 64'h103);
    check("mis_flag", 64'(misalign), 64'd0);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    check("mis_pc_next", pc, 64'h107);
`endif

    // 7: reset during stall and redirect, BOOT ignores stall
    step(1'b1, 1'b1, 1'b1, 64'h500);
    check("rst_ovr_pc", pc, 64'h0);
    check("rst_ovr_valid", 64'(ifid_valid), 64'd0);
    step(1'b0, 1'b1, 1'b0, 64'h0);
    check("reboot_pc", pc, 64'h4);
    check("reboot_valid", 64'(ifid_valid), 64'd1);
    step(1'b0, 1'b1, 1'b0, 64'h0);
    check("reboot_stall_pc", pc, 64'h4);

    // randomized run
    for (int i = 0; i < 3000; i++) begin
      logic        r, s, b;
      logic [63:0] t;
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 30);
      b = ($urandom_range(0, 99) < 12);
      t = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: t = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
        1: t = t & ~64'd3;
        default: ;
      endcase
      step(r, s, b, t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
